// File: rtl/nand2_tt_sequencer.sv
// nand2_tt_sequencer: walks a 2-input NAND gate under test through its four
// truth-table rows, holding each row for DWELL cycles and checking O at the
// end of each row. Reports busy/done/pass and a mismatch count.
// Optional first-failure log is enabled by defining NAND2_SEQ_ERRLOG_EN.
module nand2_tt_sequencer #(
  parameter int unsigned DWELL = 50
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       A,
  output logic       B,
  input  logic       O,
  output logic [1:0] row,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count
`ifdef NAND2_SEQ_ERRLOG_EN
  ,
  output logic       first_fail_vld,
  output logic [1:0] first_fail_row
`endif
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mismatch_c;
  logic             at_last_c;

  // Gate inputs come straight from the row register: {A,B} = row
  assign A = row[1];
  assign B = row[0];

  // Observed output versus the ideal NAND of the currently driven row
  assign mismatch_c = (O != ~(A & B));
  assign at_last_c  = (cnt == LAST_CNT);

  // Sequencer FSM with all status outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      row       <= 2'd0;
      cnt       <= '0;
      err_count <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
`ifdef NAND2_SEQ_ERRLOG_EN
      first_fail_vld <= 1'b0;
      first_fail_row <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            row       <= 2'd0;
            cnt       <= '0;
            err_count <= 3'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef NAND2_SEQ_ERRLOG_EN
            first_fail_vld <= 1'b0;
            first_fail_row <= 2'd0;
`endif
          end
        end

        DRIVE: begin
          if (at_last_c) begin
            if (mismatch_c) begin
              err_count <= err_count + 3'd1;
            end
`ifdef NAND2_SEQ_ERRLOG_EN
            if (mismatch_c && !first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_row <= row;
            end
`endif
            if (row == 2'd3) begin
              // Final row checked: row stays at 3 while DONE holds results
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_count == 3'd0) && !mismatch_c;
            end else begin
              row <= row + 2'd1;
              cnt <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand2_tt_sequencer.sv
// Bench for nand2_tt_sequencer: three instances (DWELL 50, 4, 2) each driving
// a behavioural gate whose fault mode is selectable. Expected run results are
// queued when a run is launched and compared when done rises.
module tb_nand2_tt_sequencer;

  logic       clk = 1'b0;
  logic [2:0] rst_v;
  logic [2:0] start_v;
  logic [2:0] a_v, b_v, o_v;
  logic [2:0] busy_v, done_v, pass_v;
  logic [5:0] row_v;
  logic [8:0] err_v;
  logic [5:0] mode_v;
`ifdef NAND2_SEQ_ERRLOG_EN
  logic [2:0] ffv_v;
  logic [5:0] ffr_v;
`endif

  typedef struct {
    int unsigned err;
    int unsigned pass;
    int unsigned ffv;
    int unsigned ffr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Gate-under-test behaviour: 0 good NAND, 1 stuck-at-1, 2 stuck-at-0, 3 AND
  function automatic logic gate_out(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'd0:    return ~(a & b);
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return a & b;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_gut
    assign o_v[g] = gate_out(mode_v[2*g +: 2], a_v[g], b_v[g]);
  end

  nand2_tt_sequencer #(.DWELL(50)) u_d50 (
    .clk(clk), .reset_n(rst_v[0]), .start(start_v[0]),
    .A(a_v[0]), .B(b_v[0]), .O(o_v[0]), .row(row_v[1:0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[2:0])
`ifdef NAND2_SEQ_ERRLOG_EN
    , .first_fail_vld(ffv_v[0]), .first_fail_row(ffr_v[1:0])
`endif
  );

  nand2_tt_sequencer #(.DWELL(4)) u_d4 (
    .clk(clk), .reset_n(rst_v[1]), .start(start_v[1]),
    .A(a_v[1]), .B(b_v[1]), .O(o_v[1]), .row(row_v[3:2]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[5:3])
`ifdef NAND2_SEQ_ERRLOG_EN
    , .first_fail_vld(ffv_v[1]), .first_fail_row(ffr_v[3:2])
`endif
  );

  nand2_tt_sequencer #(.DWELL(2)) u_d2 (
    .clk(clk), .reset_n(rst_v[2]), .start(start_v[2]),
    .A(a_v[2]), .B(b_v[2]), .O(o_v[2]), .row(row_v[5:4]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[8:6])
`ifdef NAND2_SEQ_ERRLOG_EN
    , .first_fail_vld(ffv_v[2]), .first_fail_row(ffr_v[5:4])
`endif
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference result of a whole run, derived from the truth table and fault mode
  function automatic exp_t model(input logic [1:0] m);
    exp_t e;
    e = '{err: 0, pass: 0, ffv: 0, ffr: 0};
    for (int r = 0; r < 4; r++) begin
      logic a, b, want;
      a    = (r >= 2);
      b    = (r % 2) == 1;
      want = ~(a & b);
      if (gate_out(m, a, b) != want) begin
        if (e.err == 0) begin
          e.ffv = 1;
          e.ffr = r;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic int unsigned ab_row(input int k);
    return {a_v[k], b_v[k], row_v[2*k +: 2]};
  endfunction

  // Launch (unless already launched) one run, track rows cycle by cycle and
  // score the result when done rises. Leaves start high when hold is set.
  task automatic run(input int k, input int dw, input logic [1:0] m,
                     input bit hold, input bit pre);
    int   j;
    exp_t e;
    mode_v[2*k +: 2] = m;
    exp_q.push_back(model(m));
    if (!pre) begin
      @(negedge clk);
      start_v[k] = 1'b1;
      @(posedge clk);
      #1;
    end
    check($sformatf("i%0d_start_busy", k), busy_v[k], 1);
    check($sformatf("i%0d_start_done", k), done_v[k], 0);
    check($sformatf("i%0d_start_pass", k), pass_v[k], 0);
    check($sformatf("i%0d_start_err", k), err_v[3*k +: 3], 0);
    if (!hold) start_v[k] = 1'b0;
    j = 0;
    while (!done_v[k] && j < 4 * dw + 10) begin
      if (j < 4 * dw) begin
        int unsigned r;
        r = j / dw;
        check($sformatf("i%0d_ab_row_c%0d", k, j), ab_row(k), (r << 2) | r);
      end
      @(posedge clk);
      #1;
      j++;
    end
    check($sformatf("i%0d_run_len", k), j, 4 * dw);
    if (exp_q.size() == 0) begin
      check($sformatf("i%0d_queue_empty", k), 1, 0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("i%0d_err_count", k), err_v[3*k +: 3], e.err);
      check($sformatf("i%0d_pass", k), pass_v[k], e.pass);
`ifdef NAND2_SEQ_ERRLOG_EN
      check($sformatf("i%0d_ff_vld", k), ffv_v[k], e.ffv);
      if (e.ffv != 0) check($sformatf("i%0d_ff_row", k), ffr_v[2*k +: 2], e.ffr);
`endif
    end
    check($sformatf("i%0d_done_busy", k), busy_v[k], 0);
    check($sformatf("i%0d_done_ab_row", k), ab_row(k), 4'hF);
  endtask

  initial begin
    int n;
    rst_v   = 3'b000;
    start_v = 3'b000;
    mode_v  = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("i%0d_rst_busy", k), busy_v[k], 0);
      check($sformatf("i%0d_rst_done", k), done_v[k], 0);
      check($sformatf("i%0d_rst_pass", k), pass_v[k], 0);
      check($sformatf("i%0d_rst_err", k), err_v[3*k +: 3], 0);
      check($sformatf("i%0d_rst_ab_row", k), ab_row(k), 0);
    end
    @(negedge clk);
    rst_v = 3'b111;

    // Good gate, long dwell
    run(0, 50, 2'd0, 1'b0, 1'b0);
    // Stuck-at faults, dwell 4
    run(1, 4, 2'd1, 1'b0, 1'b0);
    run(1, 4, 2'd2, 1'b0, 1'b0);
    // Inverted gate at minimum dwell
    run(2, 2, 2'd3, 1'b0, 1'b0);

    // DONE holds its results while start stays low
    repeat (5) @(posedge clk);
    #1;
    check("i2_done_hold", done_v[2], 1);
    check("i2_err_hold", err_v[8:6], 4);

    // Reset mid-run abandons everything
    mode_v[3:2] = 2'd2;
    @(negedge clk);
    start_v[1] = 1'b1;
    @(posedge clk);
    #1;
    start_v[1] = 1'b0;
    n = 0;
    while (row_v[3:2] != 2'd2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("i1_reach_row2", row_v[3:2], 2);
    @(negedge clk);
    rst_v[1] = 1'b0;
    @(posedge clk);
    #1;
    rst_v[1] = 1'b1;
    check("i1_mid_rst_busy", busy_v[1], 0);
    check("i1_mid_rst_done", done_v[1], 0);
    check("i1_mid_rst_err", err_v[5:3], 0);
    check("i1_mid_rst_ab_row", ab_row(1), 0);
    @(posedge clk);
    #1;
    check("i1_idle_stays", busy_v[1], 0);
    run(1, 4, 2'd0, 1'b0, 1'b0);

    // start held through DRIVE, then restart straight out of DONE
    run(1, 4, 2'd2, 1'b1, 1'b0);
    mode_v[3:2] = 2'd0;
    @(posedge clk);
    #1;
    run(1, 4, 2'd0, 1'b0, 1'b1);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
